// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch-queue entry layout, the fetch FSM encoding, the NOP used
// on an idle decode interface, and a word-alignment helper.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instruction memory is word addressed; the low pc bits are ignored.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with synchronous clear.
// Push while full is accepted only when a pop happens in the same cycle,
// so a full queue can stream with its count unchanged. Pointers wrap at
// DEPTH, which need not be a power of two (the pc-tag FIFO uses MAX_OUTST).
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output fetch_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Status flags and qualified push/pop strobes.
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == {CW{1'b0}});
        w_do_pop  = i_pop && !w_empty;
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage between the PC register and decode.
// Issues pipelined imem requests for pc_i, tags each accepted request with
// its pc, queues returned words in order and hands them to decode.
// Requests are credit limited so every outstanding response already owns
// a queue slot. An EX redirect (flush_i) clears the queue and converts all
// in-flight responses into a drop count that is drained before refetching.
// Optional build macro FETCH_BYPASS_EN: a response arriving at an empty
// queue is presented to decode in the same cycle.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int QDEPTH    = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_en_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o
);

    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int QCW = $clog2(QDEPTH) + 1;
    localparam int TCW = $clog2(MAX_OUTST) + 1;

    fetch_state_t   r_state;
    fetch_state_t   w_state_nxt;
    logic [OW-1:0]  r_outst;
    logic [OW-1:0]  r_drop;
    logic [OW-1:0]  w_outst_nxt;
    logic [OW-1:0]  w_drop_nxt;
    logic [31:0]    w_credit;
    logic           w_req;
    logic           w_acc;
    logic           w_rsp;
    logic           w_keep;
    logic           w_discard;
    logic           w_byp;
    logic           w_q_valid;
    logic           w_q_push;
    logic           w_q_pop;
    fetch_entry_t   w_q_wdata;
    fetch_entry_t   w_q_head;
    logic           w_q_full;
    logic           w_q_empty;
    logic [QCW-1:0] w_q_count;
    fetch_entry_t   w_tag_wdata;
    fetch_entry_t   w_tag_head;
    logic           w_tag_full;
    logic           w_tag_empty;
    logic [TCW-1:0] w_tag_count;
    logic           w_unused;

    // Request credit, handshakes and next values of the response counters.
    always_comb begin
        w_credit  = 32'(r_outst) + 32'(w_q_count);
        w_req     = (r_state == FETCH) && !flush_i &&
                    (w_credit < 32'(QDEPTH)) && (32'(r_outst) < 32'(MAX_OUTST));
        w_acc     = w_req && imem_gnt_i;
        // A response with nothing outstanding cannot belong to this block.
        w_rsp     = imem_rvalid_i && (r_outst != {OW{1'b0}});
        w_keep    = w_rsp && (r_drop == {OW{1'b0}});
        w_discard = w_rsp && (r_drop != {OW{1'b0}});
        w_outst_nxt = r_outst + OW'(w_acc) - OW'(w_rsp);
        // Everything still in flight after a redirect belongs to the old path.
        if (flush_i) begin
            w_drop_nxt = w_outst_nxt;
        end else begin
            w_drop_nxt = r_drop - OW'(w_discard);
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (flush_i && (w_drop_nxt != {OW{1'b0}})) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    w_state_nxt = DRAIN;
                end else if (w_drop_nxt == {OW{1'b0}}) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outstanding-request and drop counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outst <= {OW{1'b0}};
            r_drop  <= {OW{1'b0}};
        end else begin
            r_outst <= w_outst_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Decode-side presentation, optional bypass and queue strobes.
    always_comb begin
`ifdef FETCH_BYPASS_EN
        w_byp = w_q_empty && w_keep && !flush_i;
`else
        w_byp = 1'b0;
`endif
        w_q_valid = !w_q_empty && !flush_i;
        w_q_pop   = w_q_valid && id_ready_i;
        w_q_push  = w_keep && !flush_i && !(w_byp && id_ready_i);
        w_q_wdata = '{pc: w_tag_head.pc, instr: imem_rdata_i};
        if (w_byp) begin
            id_valid_o = 1'b1;
            id_pc_o    = w_tag_head.pc;
            id_instr_o = imem_rdata_i;
        end else if (w_q_valid) begin
            id_valid_o = 1'b1;
            id_pc_o    = w_q_head.pc;
            id_instr_o = w_q_head.instr;
        end else begin
            id_valid_o = 1'b0;
            id_pc_o    = {XLEN{1'b0}};
            id_instr_o = NOP_INSTR;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = word_align(pc_i);
    assign pc_en_o     = w_acc || flush_i;
    assign w_tag_wdata = '{pc: word_align(pc_i), instr: 32'h0000_0000};

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (flush_i),
        .i_push  (w_q_push),
        .i_data  (w_q_wdata),
        .i_pop   (w_q_pop),
        .o_head  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // pc of each accepted request, consumed by its response (kept or dropped).
    fetch_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_pc_tag (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (1'b0),
        .i_push  (w_acc),
        .i_data  (w_tag_wdata),
        .i_pop   (w_rsp),
        .o_head  (w_tag_head),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

    assign w_unused = ^{pc_i[1:0], w_tag_head.instr, w_tag_full, w_tag_empty,
                        w_tag_count, w_q_full};

endmodule
